// File: rtl/regfile_sb.sv
// regfile_sb -- parametrised register file with PC and pending-write scoreboard.
//
// Holds 2**ADDR_W registers of WIDTH bits. Register 0 always reads zero and
// ignores writes and locks. The top register is the program counter: it can
// be written like any other register, or advanced by PC_INC via incr_pc
// (an explicit write to the PC wins over the increment). Each register has a
// pending bit that lock_en sets and a write clears, so decode can stall on
// operands whose producer has not written back yet.
//
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   regr0s / regr1s       read selects
//   regr0 / regr1         combinational read data
//   regr0_busy/regr1_busy pending bit of the selected register
//   we, regws, regw       write enable, select, data
//   lock_en, lock_sel     mark a register as pending
//   incr_pc               add PC_INC to the PC
//   pc                    registered PC contents (never bypassed)
//
// There is no FSM; state is the register array (PC included) and pend.

module regfile_sb #(
    parameter int                WIDTH    = 16,
    parameter int                ADDR_W   = 3,
    parameter logic [WIDTH-1:0]  PC_INC   = 2,
    parameter logic [WIDTH-1:0]  PC_RESET = '0,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] regr0s,
    input  logic [ADDR_W-1:0] regr1s,
    output logic [WIDTH-1:0]  regr0,
    output logic [WIDTH-1:0]  regr1,
    output logic              regr0_busy,
    output logic              regr1_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] regws,
    input  logic [WIDTH-1:0]  regw,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_sel,
    input  logic              incr_pc,
    output logic [WIDTH-1:0]  pc
);

    localparam int                N      = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_SEL = '1;

    logic [WIDTH-1:0] regs [N];
    logic [N-1:0]     pend;
    logic [N-1:0]     pend_next;
    logic             pc_written;
    logic             byp0;
    logic             byp1;

    assign pc_written = we && (regws == PC_SEL);

    // Clear from a write is applied before the set from a lock, so a lock
    // and write to the same register leave it pending (new producer issued).
    always_comb begin
        pend_next = pend;
        if (we) begin
            pend_next[regws] = 1'b0;
        end
        if (lock_en) begin
            pend_next[lock_sel] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
            regs[N-1] <= PC_RESET;
            pend      <= '0;
        end else begin
            // Increment first; a same-cycle PC write below overrides it.
            if (incr_pc && !pc_written) begin
                regs[N-1] <= regs[N-1] + PC_INC;
            end
            if (we && (regws != '0)) begin
                regs[regws] <= regw;
            end
            pend <= pend_next;
        end
    end

    // Bypass forwards only the write port; the incr_pc path is never forwarded.
    assign byp0 = BYPASS && we && (regws == regr0s) && (regr0s != '0);
    assign byp1 = BYPASS && we && (regws == regr1s) && (regr1s != '0);

    always_comb begin
        if (byp0) begin
            regr0 = regw;
        end else if (regr0s == '0) begin
            regr0 = '0;
        end else begin
            regr0 = regs[regr0s];
        end
    end

    always_comb begin
        if (byp1) begin
            regr1 = regw;
        end else if (regr1s == '0) begin
            regr1 = '0;
        end else begin
            regr1 = regs[regr1s];
        end
    end

    assign regr0_busy = pend[regr0s] && !byp0;
    assign regr1_busy = pend[regr1s] && !byp1;
    assign pc         = regs[N-1];

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the CPU datapath, successor to the fixed 8×16 file. It has two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero and the top register is the program counter, with auto-increment and a reset vector. It adds per-register pending-write scoreboard bits, so the decode stage can stall on operands that are not yet written back. An optional write-to-read bypass is also included.

## Interface
- `WIDTH`, default 16: data width of every register.
- `ADDR_W`, default 3: select width. The file holds `2**ADDR_W` registers; index `2**ADDR_W-1` is the PC.
- `PC_INC`, default 2: amount added to the PC by `incr_pc`.
- `PC_RESET`, default 0: PC value after reset.
- `BYPASS`, default 1: 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `regr0s`, in, `ADDR_W`: read port 0 select.
- `regr1s`, in, `ADDR_W`: read port 1 select.
- `regr0`, out, `WIDTH`: read port 0 data (combinational).
- `regr1`, out, `WIDTH`: read port 1 data (combinational).
- `regr0_busy`, out, 1: register selected by `regr0s` has a pending write.
- `regr1_busy`, out, 1: register selected by `regr1s` has a pending write.
- `we`, in, 1: write enable.
- `regws`, in, `ADDR_W`: write select.
- `regw`, in, `WIDTH`: write data.
- `lock_en`, in, 1: mark a register as pending.
- `lock_sel`, in, `ADDR_W`: register to mark as pending.
- `incr_pc`, in, 1: add `PC_INC` to the PC.
- `pc`, out, `WIDTH`: current PC contents, registered and not bypassed.

## Operation
- Registers 1..N-1 hold `WIDTH` bits each.
- Register 0 always reads 0:
  - writes to it are discarded;
  - locks on it are discarded;
  - its busy bit is always 0.
- Read ports:
  - Read data is a pure function of the select inputs and the stored state, plus the bypass.
  - With `BYPASS=1`, if `we` is high and `regws == regrXs != 0`, then `regrX` returns `regw`.
  - The bypass never applies to the PC's `incr_pc` path.
- Write: when `we` is high and `regws != 0`, the selected register takes `regw` at the edge.
- PC update priority, highest first:
  1. reset;
  2. `we` with `regws == PC`;
  3. `incr_pc`.
- A PC write and `incr_pc` in the same cycle: the PC takes `regw`; the increment is dropped.
- PC arithmetic is modulo `2**WIDTH`; the carry out is discarded, so it wraps.
- Scoreboard: one pending bit per register (bit 0 is tied to 0).
  - `lock_en` sets `pend[lock_sel]`.
  - `we` clears `pend[regws]`.
  - Lock and write to the same register in the same cycle: the pending bit ends at 1 (a new producer was issued). The data is still written.
  - Lock and write to different registers: both actions take effect.
- `regrX_busy = pend[regrXs]`.
  - With `BYPASS=1`, busy is also forced to 0 when the bypass condition for that port holds in that cycle.
- The file has no internal FSM. State is the register array, the pending vector and the PC.

## Timing
- Reset: when `reset_n` is low at a rising edge, then:
  - all general registers become 0;
  - the PC becomes `PC_RESET`;
  - all pending bits become 0.
  - `we`, `lock_en` and `incr_pc` are ignored in that cycle.
- Outputs after reset:
  - `regr0` and `regr1` read 0, except a PC select, which reads `PC_RESET`;
  - busy outputs are 0;
  - `pc` is `PC_RESET`.
- Write latency:
  - data is visible on the read ports in the cycle after the edge;
  - with `BYPASS=1`, it is also visible combinationally in the same cycle.
- Lock latency: busy rises in the cycle after `lock_en`.
- Clear latency: busy falls in the cycle after the clearing write (same cycle with the bypass).
- Reset deasserted mid-sequence: state resumes from reset values; no lock survives reset.

## Test plan
- Reset with `reset_n=0`, `we=1`, `regws=3`, `regw=16'hBEEF`, `incr_pc=1`, then release: R3 reads 0, `pc` equals `PC_RESET`, both busy outputs are 0.
- Write `16'h1234` to R5. With `BYPASS=1`, `regr0s=5` reads `16'h1234` in the same cycle. With `BYPASS=0`, it reads 0 that cycle and `16'h1234` the next cycle. A write to R0 leaves R0 reading 0.
- Lock R2 and check `regr1_busy` = 1 on the next cycle. Write R2 = `16'h00AA` and check busy = 0 with data `16'h00AA`. Lock and write R4 in the same cycle and check `regr0_busy` = 1 on the next cycle with data updated.
- Apply `incr_pc` from `16'hFFFE` with `PC_INC=2`: the PC wraps to `16'h0000`.
- Assert `incr_pc` while writing `16'h0100` to the PC: the PC becomes `16'h0100`, not `16'h0102`.
- Instantiate `WIDTH=32`, `ADDR_W=4`: write `32'hDEADBEEF` to R14, read it on both ports, and check the PC is R15.
